// File: rtl/wheel_pwm_driver.sv
// wheel_pwm_driver: two-wheel PWM driver with duty ramping, dead time on reversal and emergency stop
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   bin_speed_wheel1/2 [2:0]  per-wheel command: bit2 direction (0 fwd, 1 rev), bits1:0 speed code
//   estop                     level-sensitive emergency stop
//   pwm_l/pwm_r               registered PWM drive
//   dir_l/dir_r               registered H-bridge direction
//   duty_l/duty_r [7:0]       currently applied duty
//   busy                      either wheel ramping or in dead time
module wheel_pwm_driver #(
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 5,
    parameter int DEADTIME  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bin_speed_wheel1,
    input  logic [2:0] bin_speed_wheel2,
    input  logic       estop,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [7:0] duty_l,
    output logic [7:0] duty_r,
    output logic       busy
);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = $clog2(DEADTIME + 1);

    typedef enum logic {RUN, DEAD} state_t;

    logic [7:0]    r_pwm_cnt;
    logic [PW-1:0] r_pre;
    logic          w_tick;
    logic [2:0]    w_cmd [2];
    logic [1:0]    w_pwm;
    logic [1:0]    w_dir;
    logic [1:0]    w_busy;
    logic [7:0]    w_duty [2];

    assign w_cmd[0] = bin_speed_wheel1;
    assign w_cmd[1] = bin_speed_wheel2;
    assign w_tick   = (r_pre == PW'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= 8'd0;
            r_pre     <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == 8'd254) ? 8'd0 : r_pwm_cnt + 8'd1;
            r_pre     <= w_tick ? '0 : r_pre + PW'(1);
        end
    end

    for (genvar w = 0; w < 2; w++) begin : g_wheel
        state_t        r_state, w_state_nxt;
        logic [DW-1:0] r_dead, w_dead_nxt;
        logic [7:0]    r_duty, w_duty_nxt;
        logic          r_dir, w_dir_nxt;
        logic          r_pwm;
        logic [7:0]    w_tab, w_eff, w_ramp;
        logic [8:0]    w_up;
        logic          w_dn_big;

        always_comb begin
            w_tab = w_cmd[w][1] ? (w_cmd[w][0] ? 8'd255 : 8'd170) : (w_cmd[w][0] ? 8'd85 : 8'd0);
            // A pending reversal ramps to zero first; the new direction is only applied after dead time
            w_eff = (w_cmd[w][2] == r_dir) ? w_tab : 8'd0;
            // 9-bit arithmetic saturates exactly at the target without 8-bit wrap
            w_up = {1'b0, r_duty} + 9'(RAMP_STEP);
            w_dn_big = {1'b0, r_duty} > ({1'b0, w_eff} + 9'(RAMP_STEP));
            w_ramp = (r_duty < w_eff) ? ((w_up >= {1'b0, w_eff}) ? w_eff : w_up[7:0])
                                      : (w_dn_big ? r_duty - 8'(RAMP_STEP) : w_eff);
            w_state_nxt = r_state;
            w_dead_nxt = r_dead;
            w_duty_nxt = r_duty;
            w_dir_nxt = r_dir;
            if (estop) begin
                w_state_nxt = RUN;
                w_dead_nxt = '0;
                w_duty_nxt = 8'd0;
            end else if (r_state == DEAD) begin
                w_dead_nxt = r_dead - DW'(1);
                w_duty_nxt = 8'd0;
                if (r_dead == DW'(1)) begin
                    w_state_nxt = RUN;
                    w_dir_nxt = w_cmd[w][2];
                end
            end else if (r_duty == 8'd0 && w_cmd[w][2] != r_dir) begin
                w_state_nxt = DEAD;
                w_dead_nxt = DW'(DEADTIME);
            end else if (w_tick) begin
                w_duty_nxt = w_ramp;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= RUN;
                r_dead  <= '0;
                r_duty  <= 8'd0;
                r_dir   <= 1'b0;
                r_pwm   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_dead  <= w_dead_nxt;
                r_duty  <= w_duty_nxt;
                r_dir   <= w_dir_nxt;
                r_pwm   <= !estop && (r_pwm_cnt < r_duty);
            end
        end

        assign w_pwm[w]  = r_pwm;
        assign w_dir[w]  = r_dir;
        assign w_duty[w] = r_duty;
        assign w_busy[w] = (r_state == DEAD) || (r_duty != w_eff);
    end

    assign pwm_l  = w_pwm[0];
    assign pwm_r  = w_pwm[1];
    assign dir_l  = w_dir[0];
    assign dir_r  = w_dir[1];
    assign duty_l = w_duty[0];
    assign duty_r = w_duty[1];
    assign busy   = |w_busy;
endmodule

// File: tb/tb_wheel_pwm_driver.sv
// tb_wheel_pwm_driver: directed self-checking bench for wheel_pwm_driver (RAMP_DIV=4, RAMP_STEP=5, DEADTIME=8)
module tb_wheel_pwm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       estop = 1'b0;
    logic [2:0] w1 = 3'b000;
    logic [2:0] w2 = 3'b000;
    logic       pwm_l, pwm_r, dir_l, dir_r, busy;
    logic [7:0] duty_l, duty_r;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         hi;

    wheel_pwm_driver #(.RAMP_DIV(4), .RAMP_STEP(5), .DEADTIME(8)) dut (
        .clk(clk),
        .rst(rst),
        .bin_speed_wheel1(w1),
        .bin_speed_wheel2(w2),
        .estop(estop),
        .pwm_l(pwm_l),
        .pwm_r(pwm_r),
        .dir_l(dir_l),
        .dir_r(dir_r),
        .duty_l(duty_l),
        .duty_r(duty_r),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; ramp ticks land on edges where this is a multiple of 4
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic to_tick();
        do @(negedge clk); while (cyc % 4 != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) to_tick();
    endtask

    task automatic do_reset(input logic [2:0] c1, input logic [2:0] c2);
        @(negedge clk);
        rst = 1'b1;
        estop = 1'b0;
        w1 = c1;
        w2 = c2;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_pwm(input bit left, output int n);
        n = 0;
        repeat (255) begin
            @(negedge clk);
            n += left ? int'(pwm_l) : int'(pwm_r);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_duty_l", int'(duty_l), 0);
        check("rst_duty_r", int'(duty_r), 0);
        check("rst_pwm_l", int'(pwm_l), 0);
        check("rst_pwm_r", int'(pwm_r), 0);
        check("rst_dir_l", int'(dir_l), 0);
        check("rst_dir_r", int'(dir_r), 0);
        check("rst_busy_idle", int'(busy), 0);
        w1 = 3'b011;
        #1;
        check("rst_busy_cmd", int'(busy), 1);
        rst = 1'b0;
        for (int k = 1; k <= 51; k++) begin
            repeat (3) @(negedge clk);
            check($sformatf("ramp_hold_%0d", k), int'(duty_l), 5 * (k - 1));
            @(negedge clk);
            check($sformatf("ramp_step_%0d", k), int'(duty_l), 5 * k);
        end
        check("full_busy", int'(busy), 0);
        check("full_dir", int'(dir_l), 0);
        check("full_duty_r", int'(duty_r), 0);
        @(negedge clk);
        count_pwm(1'b1, hi);
        check("pwm_255_count", hi, 255);

        do_reset(3'b001, 3'b000);
        ticks(17);
        check("fwd85_duty", int'(duty_l), 85);
        check("fwd85_busy", int'(busy), 0);
        @(negedge clk);
        count_pwm(1'b1, hi);
        check("pwm_85_count", hi, 85);
        w1 = 3'b101;
        #1;
        check("rev_busy", int'(busy), 1);
        ticks(17);
        check("rev_down_duty", int'(duty_l), 0);
        check("rev_down_dir", int'(dir_l), 0);
        @(negedge clk);
        check("dead_busy", int'(busy), 1);
        check("dead_pwm", int'(pwm_l), 0);
        repeat (3) @(negedge clk);
        w1 = 3'b001;
        repeat (2) @(negedge clk);
        w1 = 3'b101;
        repeat (2) @(negedge clk);
        check("dead_end_dir", int'(dir_l), 0);
        check("dead_end_busy", int'(busy), 1);
        check("dead_end_pwm", int'(pwm_l), 0);
        @(negedge clk);
        check("dead_exit_dir", int'(dir_l), 1);
        check("dead_exit_duty", int'(duty_l), 0);
        ticks(1);
        check("rev_up_first", int'(duty_l), 5);
        ticks(16);
        check("rev_up_duty", int'(duty_l), 85);
        check("rev_up_dir", int'(dir_l), 1);
        check("rev_up_busy", int'(busy), 0);

        do_reset(3'b010, 3'b000);
        ticks(34);
        check("r170_duty", int'(duty_l), 170);
        w1 = 3'b110;
        ticks(14);
        check("revert_down", int'(duty_l), 100);
        check("revert_dir_a", int'(dir_l), 0);
        w1 = 3'b010;
        ticks(1);
        check("revert_up1", int'(duty_l), 105);
        check("revert_busy", int'(busy), 1);
        ticks(13);
        check("revert_full", int'(duty_l), 170);
        check("revert_dir_b", int'(dir_l), 0);
        check("revert_idle", int'(busy), 0);

        do_reset(3'b000, 3'b010);
        ticks(34);
        check("r_170", int'(duty_r), 170);
        check("l_idle", int'(duty_l), 0);
        estop = 1'b1;
        @(negedge clk);
        check("estop_duty", int'(duty_r), 0);
        check("estop_pwm", int'(pwm_r), 0);
        check("estop_busy", int'(busy), 1);
        check("estop_dir", int'(dir_r), 0);
        repeat (2) @(negedge clk);
        check("estop_hold_duty", int'(duty_r), 0);
        check("estop_hold_pwm", int'(pwm_r), 0);
        estop = 1'b0;
        ticks(1);
        check("estop_rel_first", int'(duty_r), 5);
        ticks(33);
        check("estop_rel_full", int'(duty_r), 170);

        do_reset(3'b001, 3'b000);
        ticks(17);
        w1 = 3'b101;
        ticks(17);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", int'(busy), 1);
        estop = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_dir", int'(dir_l), 0);
        estop = 1'b0;
        @(negedge clk);
        check("redead_busy", int'(busy), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_duty", int'(duty_l), 0);
        check("mid_rst_dir", int'(dir_l), 0);
        check("mid_rst_pwm", int'(pwm_l), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;

        do_reset(3'b000, 3'b000);
        count_pwm(1'b1, hi);
        check("pwm_0_count", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
